fetch_stage: RTL and testbench
==============================

// Module: fetch_stage
// PURPOSE
//  Parametrised instruction-fetch stage for the pipelined RV32I core; successor to the single-cycle PC block.
//  Owns the PC register and drives the instruction-memory address.
//  Registers the fetched word into an IF/ID pipeline register, with stall, flush/redirect and optional BTB prediction.
//  Sits between the instruction memory and the decode stage.
// PARAMETERS
//  DATA_WIDTH   32             instruction word width
//  ADDR_WIDTH   32             PC / address width
//  RESET_PC     32'h0000_0000  PC loaded on reset; bits [1:0] must be 0
//  BTB_ENTRIES  16             BTB depth, power of 2, >=2; used only with BTB_EN
// PORTS
//  clk              in   1           clock, rising edge
//  rst              in   1           asynchronous reset, active-high
//  imem_addr        out  ADDR_WIDTH  current PC to instruction memory
//  imem_rdata       in   DATA_WIDTH  instruction at imem_addr, combinational same-cycle read
//  stall_i          in   1           hold PC and IF/ID (load-use hazard)
//  redirect_i       in   1           EX resolved wrong path; flush and reload PC
//  redirect_pc_i    in   ADDR_WIDTH  correct next PC on redirect
//  bru_valid_i      in   1           resolved branch/jump in EX this cycle (BTB update)
//  bru_pc_i         in   ADDR_WIDTH  PC of the resolved branch
//  bru_taken_i      in   1           branch was taken
//  bru_target_i     in   ADDR_WIDTH  resolved taken target
//  id_valid_o       out  1           IF/ID holds a real instruction
//  id_instr_o       out  DATA_WIDTH  IF/ID instruction
//  id_pc_o          out  ADDR_WIDTH  IF/ID PC
//  id_pc_plus4_o    out  ADDR_WIDTH  IF/ID PC+4
//  id_pred_taken_o  out  1           fetch predicted taken
//  id_pred_target_o out  ADDR_WIDTH  PC fetch followed after this instruction
// BEHAVIOUR
//  - Reset (async, immediate): PC=RESET_PC; id_valid_o=0; id_instr_o=NOP (32'h0000_0013); id_pc_o=0.
//    Also on reset: id_pc_plus4_o=0, id_pred_taken_o=0, id_pred_target_o=0, all BTB valid bits cleared.
//  - imem_addr = PC continuously. Word at PC appears on id_* one cycle later (latency 1).
//  - Next-PC priority per edge: redirect_i > stall_i > BTB hit > PC+4.
//  - redirect_i: PC <= {redirect_pc_i[ADDR_WIDTH-1:2],2'b00}; IF/ID flushed (valid=0, instr=NOP, pred_taken=0).
//    redirect_i overrides a simultaneous stall_i.
//  - stall_i (no redirect): PC and all IF/ID fields hold their values.
//  - Normal advance: IF/ID <= {1, imem_rdata, PC, PC+4, pred_taken, next_pc}; PC <= next_pc.
//  - PC+4 wraps modulo 2^ADDR_WIDTH (0xFFFF_FFFC -> 0x0); no overflow flag.
//  - The first fetch after reset deassertion is RESET_PC; id_valid_o rises one cycle later.
//  - bru_* ports are ignored while rst is high.
// CONFIGURATION
//  BTB_EN defined:
//   - Direct-mapped BTB, IDX=$clog2(BTB_ENTRIES). Index = PC[IDX+1:2]; tag = PC[ADDR_WIDTH-1:IDX+2]; entry = {valid, tag, target}.
//   - Lookup on PC is combinational. A hit gives next_pc=target and pred_taken=1.
//   - Update at edge when bru_valid_i:
//     - taken: write {1, tag, bru_target_i}.
//     - not taken and tag matches: clear valid.
//   - A same-cycle lookup on the index being updated sees the old entry.
//   - Updates proceed during stall_i and redirect_i.
//  BTB_EN undefined: no BTB storage; pred_taken=0; next_pc=PC+4; bru_* inputs unused.
// STRUCTURE
//  - fetch_pkg:
//    - localparam NOP_INSTR=32'h0000_0013.
//    - typedef struct packed if_id_t {valid, instr, pc, pc_plus4, pred_taken, pred_target}.
//  - Sub-module fetch_btb (lookup + update, async-reset valid bits), instantiated only under `ifdef BTB_EN.
//  - Top holds the PC register, next-PC mux and the if_id_t register.
// TESTING
//  1. Assert rst mid-cycle -> imem_addr=0x0, id_valid_o=0, id_instr_o=0x00000013 before the next edge.
//  2. Release reset, imem_rdata=imem_addr -> after 3 edges: id_pc_o=0x8, id_instr_o=0x8, id_pc_plus4_o=0xC, imem_addr=0xC.
//  3. stall_i high 2 cycles with PC=0x10 -> imem_addr stays 0x10; id_* unchanged.
//     After release: id_pc_o=0x10, no fetch lost.
//  4. redirect_i=1, redirect_pc_i=0x103, stall_i=1 together -> next imem_addr=0x100, id_valid_o=0.
//     One cycle later id_pc_o=0x100.
//  5. BTB_EN: bru update pc=0x20 taken target=0x80.
//     - Later fetch of 0x20 -> next imem_addr=0x80, id_pred_taken_o=1, id_pred_target_o=0x80.
//     - Not-taken update for 0x20, then refetch 0x20 -> next imem_addr=0x24.
//  6. RESET_PC=0xFFFFFFFC -> first fetch 0xFFFFFFFC, next imem_addr=0x0; id_pc_plus4_o=0x0.

Source files
------------

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the RV32I instruction-fetch stage.
// Provides the canonical NOP encoding and the IF/ID pipeline bundle.
package fetch_pkg;

   localparam int XLEN = 32;

   // addi x0, x0, 0
   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   typedef struct packed {
      logic            valid;
      logic [XLEN-1:0] instr;
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] pc_plus4;
      logic            pred_taken;
      logic [XLEN-1:0] pred_target;
   } if_id_t;

   // Bundle value held after reset and after a flush.
   function automatic if_id_t if_id_bubble();
      if_id_t b;
      b             = '0;
      b.instr       = NOP_INSTR;
      return b;
   endfunction

endpackage

// File: rtl/fetch_btb.sv
// fetch_btb: direct-mapped branch target buffer, combinational lookup.
// Ports: clk, rst (async, active-high); lookup_pc_i -> hit_o, target_o;
//        upd_valid_i/upd_pc_i/upd_taken_i/upd_target_i write at the edge.
module fetch_btb
   import fetch_pkg::*;
#(
   parameter int ADDR_WIDTH = 32,
   parameter int ENTRIES    = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [ADDR_WIDTH-1:0] lookup_pc_i,
   output logic                  hit_o,
   output logic [ADDR_WIDTH-1:0] target_o,
   input  logic                  upd_valid_i,
   input  logic [ADDR_WIDTH-1:0] upd_pc_i,
   input  logic                  upd_taken_i,
   input  logic [ADDR_WIDTH-1:0] upd_target_i
);

   localparam int IDX   = $clog2(ENTRIES);
   localparam int TAG_W = ADDR_WIDTH - IDX - 2;

   logic [ENTRIES-1:0]    valid_q;
   logic [ENTRIES-1:0]    valid_d;
   logic [TAG_W-1:0]      tag_mem [ENTRIES];
   logic [ADDR_WIDTH-1:0] tgt_mem [ENTRIES];

   logic [IDX-1:0]   rd_idx;
   logic [IDX-1:0]   wr_idx;
   logic [TAG_W-1:0] rd_tag;
   logic [TAG_W-1:0] wr_tag;
   logic             wr_en;

   always_comb begin
      rd_idx   = lookup_pc_i[IDX+1:2];
      rd_tag   = lookup_pc_i[ADDR_WIDTH-1:IDX+2];
      hit_o    = valid_q[rd_idx] && (tag_mem[rd_idx] == rd_tag);
      target_o = tgt_mem[rd_idx];

      wr_idx   = upd_pc_i[IDX+1:2];
      wr_tag   = upd_pc_i[ADDR_WIDTH-1:IDX+2];
      wr_en    = upd_valid_i && upd_taken_i;

      valid_d  = valid_q;
      if (wr_en) begin
         valid_d[wr_idx] = 1'b1;
      end else if (upd_valid_i && (tag_mem[wr_idx] == wr_tag)) begin
         // Only drop the entry if it belongs to this branch.
         valid_d[wr_idx] = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) valid_q <= '0;
      else     valid_q <= valid_d;
   end

   // Payload needs no reset: it is qualified by valid_q.
   always_ff @(posedge clk) begin
      if (wr_en && !rst) begin
         tag_mem[wr_idx] <= wr_tag;
         tgt_mem[wr_idx] <= upd_target_i;
      end
   end

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: PC register, next-PC selection and IF/ID register.
// Ports: clk, rst (async, active-high); imem_addr/imem_rdata to I-mem;
//        stall_i, redirect_i/redirect_pc_i from hazard/EX; bru_* BTB
//        update; id_* IF/ID outputs. Define BTB_EN to add the BTB.
module fetch_stage
   import fetch_pkg::*;
#(
   parameter int                    DATA_WIDTH  = 32,
   parameter int                    ADDR_WIDTH  = 32,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC    = 32'h0000_0000,
   parameter int                    BTB_ENTRIES = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   output logic [ADDR_WIDTH-1:0] imem_addr,
   input  logic [DATA_WIDTH-1:0] imem_rdata,
   input  logic                  stall_i,
   input  logic                  redirect_i,
   input  logic [ADDR_WIDTH-1:0] redirect_pc_i,
   input  logic                  bru_valid_i,
   input  logic [ADDR_WIDTH-1:0] bru_pc_i,
   input  logic                  bru_taken_i,
   input  logic [ADDR_WIDTH-1:0] bru_target_i,
   output logic                  id_valid_o,
   output logic [DATA_WIDTH-1:0] id_instr_o,
   output logic [ADDR_WIDTH-1:0] id_pc_o,
   output logic [ADDR_WIDTH-1:0] id_pc_plus4_o,
   output logic                  id_pred_taken_o,
   output logic [ADDR_WIDTH-1:0] id_pred_target_o
);

   logic [ADDR_WIDTH-1:0] pc_q;
   logic [ADDR_WIDTH-1:0] pc_d;
   logic [ADDR_WIDTH-1:0] pc_plus4;
   logic [ADDR_WIDTH-1:0] next_pc;
   if_id_t                if_id_q;
   if_id_t                if_id_d;
   logic                  btb_hit;
   logic [ADDR_WIDTH-1:0] btb_target;

`ifdef BTB_EN
   fetch_btb #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .ENTRIES    (BTB_ENTRIES)
   ) u_btb (
      .clk          (clk),
      .rst          (rst),
      .lookup_pc_i  (pc_q),
      .hit_o        (btb_hit),
      .target_o     (btb_target),
      .upd_valid_i  (bru_valid_i),
      .upd_pc_i     (bru_pc_i),
      .upd_taken_i  (bru_taken_i),
      .upd_target_i (bru_target_i)
   );
`else
   logic unused_bru;
   assign unused_bru = ^{bru_valid_i, bru_pc_i, bru_taken_i,
                         bru_target_i, 32'(BTB_ENTRIES)};
   assign btb_hit    = 1'b0;
   assign btb_target = '0;
`endif

   always_comb begin
      // Natural wrap at 2^ADDR_WIDTH.
      pc_plus4 = pc_q + ADDR_WIDTH'(4);
      next_pc  = btb_hit ? btb_target : pc_plus4;

      pc_d     = pc_q;
      if_id_d  = if_id_q;

      if (redirect_i) begin
         pc_d    = {redirect_pc_i[ADDR_WIDTH-1:2], 2'b00};
         if_id_d = if_id_bubble();
      end else if (!stall_i) begin
         pc_d                = next_pc;
         if_id_d.valid       = 1'b1;
         if_id_d.instr       = imem_rdata;
         if_id_d.pc          = pc_q;
         if_id_d.pc_plus4    = pc_plus4;
         if_id_d.pred_taken  = btb_hit;
         if_id_d.pred_target = next_pc;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_q    <= RESET_PC;
         if_id_q <= if_id_bubble();
      end else begin
         pc_q    <= pc_d;
         if_id_q <= if_id_d;
      end
   end

   assign imem_addr        = pc_q;
   assign id_valid_o       = if_id_q.valid;
   assign id_instr_o       = if_id_q.instr;
   assign id_pc_o          = if_id_q.pc;
   assign id_pc_plus4_o    = if_id_q.pc_plus4;
   assign id_pred_taken_o  = if_id_q.pred_taken;
   assign id_pred_target_o = if_id_q.pred_target;

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed self-checking bench for fetch_stage.
// Instruction memory returns its own address as the instruction word.
module tb_fetch_stage;

   logic        clk;
   logic        rst;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata;
   logic        stall;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        bru_valid;
   logic [31:0] bru_pc;
   logic        bru_taken;
   logic [31:0] bru_target;
   logic        id_valid;
   logic [31:0] id_instr;
   logic [31:0] id_pc;
   logic [31:0] id_pc_plus4;
   logic        id_pred_taken;
   logic [31:0] id_pred_target;

   logic [31:0] w_addr;
   logic [31:0] w_rdata;
   logic        w_valid;
   logic [31:0] w_instr;
   logic [31:0] w_pc;
   logic [31:0] w_pc_plus4;
   logic        w_pred_taken;
   logic [31:0] w_pred_target;

   int n_cmp;
   int n_bad;

   assign imem_rdata = imem_addr;
   assign w_rdata    = w_addr;

   fetch_stage dut (
      .clk              (clk),
      .rst              (rst),
      .imem_addr        (imem_addr),
      .imem_rdata       (imem_rdata),
      .stall_i          (stall),
      .redirect_i       (redirect),
      .redirect_pc_i    (redirect_pc),
      .bru_valid_i      (bru_valid),
      .bru_pc_i         (bru_pc),
      .bru_taken_i      (bru_taken),
      .bru_target_i     (bru_target),
      .id_valid_o       (id_valid),
      .id_instr_o       (id_instr),
      .id_pc_o          (id_pc),
      .id_pc_plus4_o    (id_pc_plus4),
      .id_pred_taken_o  (id_pred_taken),
      .id_pred_target_o (id_pred_target)
   );

   fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
      .clk              (clk),
      .rst              (rst),
      .imem_addr        (w_addr),
      .imem_rdata       (w_rdata),
      .stall_i          (1'b0),
      .redirect_i       (1'b0),
      .redirect_pc_i    (32'h0),
      .bru_valid_i      (1'b0),
      .bru_pc_i         (32'h0),
      .bru_taken_i      (1'b0),
      .bru_target_i     (32'h0),
      .id_valid_o       (w_valid),
      .id_instr_o       (w_instr),
      .id_pc_o          (w_pc),
      .id_pc_plus4_o    (w_pc_plus4),
      .id_pred_taken_o  (w_pred_taken),
      .id_pred_target_o (w_pred_target)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag,
                        input logic [31:0] got,
                        input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %08h, expected %08h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      n_cmp       = 0;
      n_bad       = 0;
      rst         = 1'b0;
      stall       = 1'b0;
      redirect    = 1'b0;
      redirect_pc = 32'h0;
      bru_valid   = 1'b0;
      bru_pc      = 32'h0;
      bru_taken   = 1'b0;
      bru_target  = 32'h0;

      // Reset mid-cycle, checked before any clock edge.
      #3 rst = 1'b1;
      #1;
      check("rst_addr",   imem_addr,     32'h0);
      check("rst_valid",  32'(id_valid), 32'h0);
      check("rst_instr",  id_instr,      32'h0000_0013);
      check("rst_pc",     id_pc,         32'h0);
      check("rst_plus4",  id_pc_plus4,   32'h0);
      check("rst_pred",   32'(id_pred_taken), 32'h0);
      check("rst_ptgt",   id_pred_target, 32'h0);
      check("w_rst_addr", w_addr,        32'hFFFF_FFFC);

      step();
      step();
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("rel_valid", 32'(id_valid), 32'h0);
      check("rel_addr",  imem_addr,     32'h0);

      // Edge 1: first fetch of RESET_PC lands in IF/ID.
      step();
      check("e1_valid", 32'(id_valid), 32'h1);
      check("e1_pc",    id_pc,         32'h0);
      check("e1_addr",  imem_addr,     32'h4);
      check("w_pc",     w_pc,          32'hFFFF_FFFC);
      check("w_plus4",  w_pc_plus4,    32'h0);
      check("w_addr",   w_addr,        32'h0);
      check("w_instr",  w_instr,       32'hFFFF_FFFC);

      step();
      step();
      check("e3_pc",    id_pc,          32'h8);
      check("e3_instr", id_instr,       32'h8);
      check("e3_plus4", id_pc_plus4,    32'hC);
      check("e3_addr",  imem_addr,      32'hC);
      check("e3_pred",  32'(id_pred_taken), 32'h0);
      check("e3_ptgt",  id_pred_target, 32'hC);

      // PC is 0x10 after this edge; stall two cycles.
      step();
      check("e4_addr", imem_addr, 32'h10);
      stall = 1'b1;
      step();
      step();
      check("st_addr",  imem_addr, 32'h10);
      check("st_pc",    id_pc,     32'hC);
      check("st_instr", id_instr,  32'hC);
      check("st_valid", 32'(id_valid), 32'h1);
      stall = 1'b0;
      step();
      check("ust_pc",    id_pc,     32'h10);
      check("ust_instr", id_instr,  32'h10);
      check("ust_addr",  imem_addr, 32'h14);
      step();
      check("ust2_pc", id_pc, 32'h14);

      // Redirect wins over stall; low PC bits are dropped.
      redirect    = 1'b1;
      redirect_pc = 32'h103;
      stall       = 1'b1;
      step();
      redirect = 1'b0;
      stall    = 1'b0;
      check("rd_addr",  imem_addr,     32'h100);
      check("rd_valid", 32'(id_valid), 32'h0);
      check("rd_instr", id_instr,      32'h0000_0013);
      check("rd_pred",  32'(id_pred_taken), 32'h0);
      step();
      check("rd1_pc",    id_pc,         32'h100);
      check("rd1_valid", 32'(id_valid), 32'h1);
      check("rd1_addr",  imem_addr,     32'h104);

`ifdef BTB_EN
      // Train 0x20 -> 0x80 while redirecting to 0x20.
      bru_valid   = 1'b1;
      bru_pc      = 32'h20;
      bru_taken   = 1'b1;
      bru_target  = 32'h80;
      redirect    = 1'b1;
      redirect_pc = 32'h20;
      step();
      bru_valid = 1'b0;
      redirect  = 1'b0;
      check("bt_addr", imem_addr, 32'h20);
      step();
      check("bt_next",  imem_addr,      32'h80);
      check("bt_pred",  32'(id_pred_taken), 32'h1);
      check("bt_ptgt",  id_pred_target, 32'h80);
      check("bt_pc",    id_pc,          32'h20);

      // Not-taken update drops the entry.
      bru_valid   = 1'b1;
      bru_pc      = 32'h20;
      bru_taken   = 1'b0;
      redirect    = 1'b1;
      redirect_pc = 32'h20;
      step();
      bru_valid = 1'b0;
      redirect  = 1'b0;
      check("bn_addr", imem_addr, 32'h20);
      step();
      check("bn_next", imem_addr, 32'h24);
      check("bn_pred", 32'(id_pred_taken), 32'h0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
